// File: rtl/switch_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Package  : switch_cfg_pkg
// Brief    : Encodings, entry mapping and FSM states for the switch-box loader.
// Revision : 1.0
// ============================================================================
package switch_cfg_pkg;

    localparam logic [2:0] SIDE_NONE   = 3'd0;
    localparam logic [2:0] SIDE_TOP    = 3'd1;
    localparam logic [2:0] SIDE_RIGHT  = 3'd2;
    localparam logic [2:0] SIDE_BOTTOM = 3'd3;
    localparam logic [2:0] SIDE_LEFT   = 3'd4;

    localparam logic [7:0] FRAME_HDR   = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CKSUM   = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam int ENTRY_BITS = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    function automatic int num_entries(input int ntb, input int nlr);
        return 2 * ntb + 2 * nlr;
    endfunction

    // Entry order: top, bottom, left, right.
    function automatic logic [2:0] entry_side(input int k, input int ntb, input int nlr);
        if (k < ntb)             return SIDE_TOP;
        if (k < 2 * ntb)         return SIDE_BOTTOM;
        if (k < 2 * ntb + nlr)   return SIDE_LEFT;
        return SIDE_RIGHT;
    endfunction

    function automatic logic [2:0] entry_idx(input int k, input int ntb, input int nlr);
        int r;
        if (k < ntb)                r = k;
        else if (k < 2 * ntb)       r = k - ntb;
        else if (k < 2 * ntb + nlr) r = k - 2 * ntb;
        else                        r = k - 2 * ntb - nlr;
        return 3'(r);
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_entry_check.sv
`default_nettype none
// ============================================================================
// Module   : switch_entry_check
// Brief    : Combinational legality check of one selector byte for entry k.
// Revision : 1.0
// ============================================================================
module switch_entry_check
    import switch_cfg_pkg::*;
#(
    parameter int NTB = 5,
    parameter int NLR = 4,
    parameter int KW  = 5
) (
    input  logic [7:0]    i_byte,
    input  logic [KW-1:0] i_k,
    output logic          o_illegal
);

    logic [2:0] w_side;
    logic [2:0] w_idx;
    logic [2:0] w_own_side;
    logic [2:0] w_own_idx;

    assign w_side     = i_byte[2:0];
    assign w_idx      = i_byte[5:3];
    assign w_own_side = entry_side(int'(i_k), NTB, NLR);
    assign w_own_idx  = entry_idx(int'(i_k), NTB, NLR);

    always_comb begin
        o_illegal = (i_byte[7:6] != 2'b00);
        case (w_side)
            SIDE_NONE: ;
            SIDE_TOP, SIDE_BOTTOM: if (int'(w_idx) >= NTB) o_illegal = 1'b1;
            SIDE_RIGHT, SIDE_LEFT: if (int'(w_idx) >= NLR) o_illegal = 1'b1;
            default:               o_illegal = 1'b1;
        endcase
        // A selector may not route a port back onto itself.
        if ((w_side != SIDE_NONE) && (w_side == w_own_side) && (w_idx == w_own_idx))
            o_illegal = 1'b1;
    end

endmodule
`default_nettype wire

// File: rtl/switch_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : switch_cfg_loader
// Brief    : Receives, validates and atomically commits a switch-box route frame.
// Revision : 1.0
// ============================================================================
module switch_cfg_loader #(
    parameter int NTB     = 5,
    parameter int NLR     = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cfg_valid,
    input  logic [7:0]                       cfg_data,
    output logic                             cfg_ready,
    input  logic                             clear,
    output logic [6*(2*NTB+2*NLR)-1:0]       cfg_out,
    output logic                             busy,
    output logic                             cfg_done,
    output logic                             cfg_err,
    output logic [1:0]                       err_code
);
    import switch_cfg_pkg::*;

    localparam int NENT = num_entries(NTB, NLR);
    localparam int CW   = $clog2(NENT + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);

    state_e                    r_state;
    state_e                    w_state_nxt;
    logic [CW-1:0]             r_cnt;
    logic [7:0]                r_acc;
    logic                      r_illegal;
    logic                      r_cksum_bad;
    logic [TW-1:0]             r_idle;
    logic [ENTRY_BITS*NENT-1:0] r_shadow;
    logic [ENTRY_BITS*NENT-1:0] r_active;
    logic                      r_done;
    logic                      r_err;
    logic [1:0]                r_err_code;

    logic       w_accept;
    logic       w_entry_illegal;
    logic       w_timeout;
    logic       w_commit;
    logic       w_fail;
    logic [1:0] w_fail_code;

    assign cfg_ready = (r_state != ST_CHECK);
    assign busy      = (r_state != ST_IDLE);
    assign cfg_out   = r_active;
    assign cfg_done  = r_done;
    assign cfg_err   = r_err;
    assign err_code  = r_err_code;

    assign w_accept  = cfg_valid && cfg_ready && !clear;
    assign w_timeout = (r_state == ST_LOAD) && !w_accept && (r_idle == TW'(TIMEOUT - 1));

    switch_entry_check #(
        .NTB (NTB),
        .NLR (NLR),
        .KW  (CW)
    ) u_entry_check (
        .i_byte    (cfg_data),
        .i_k       (r_cnt),
        .o_illegal (w_entry_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_fail      = 1'b0;
        w_fail_code = ERR_NONE;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (cfg_data == FRAME_HDR)) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_accept && (r_cnt == CW'(NENT))) begin
                    w_state_nxt = ST_CHECK;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_fail      = 1'b1;
                    w_fail_code = ERR_TIMEOUT;
                end
            end
            ST_CHECK: begin
                w_state_nxt = ST_IDLE;
                if (r_illegal) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_ILLEGAL;
                end else if (r_cksum_bad) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_CKSUM;
                end else begin
                    w_commit    = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_commit    = 1'b0;
            w_fail      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_illegal   <= 1'b0;
            r_cksum_bad <= 1'b0;
            r_idle      <= '0;
            r_shadow    <= '0;
            r_active    <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_done <= w_commit;
            r_err  <= w_fail;
            if (clear) begin
                r_active    <= '0;
                r_err_code  <= ERR_NONE;
                r_cnt       <= '0;
                r_acc       <= '0;
                r_illegal   <= 1'b0;
                r_cksum_bad <= 1'b0;
                r_idle      <= '0;
            end else begin
                if (w_commit) begin
                    r_active   <= r_shadow;
                    r_err_code <= ERR_NONE;
                end
                if (w_fail) r_err_code <= w_fail_code;

                if ((r_state == ST_IDLE) && w_accept && (cfg_data == FRAME_HDR)) begin
                    r_cnt       <= '0;
                    r_acc       <= '0;
                    r_illegal   <= 1'b0;
                    r_cksum_bad <= 1'b0;
                    r_idle      <= '0;
                end else if (r_state == ST_LOAD) begin
                    if (w_accept) begin
                        r_idle <= '0;
                        if (r_cnt == CW'(NENT)) begin
                            r_cksum_bad <= (cfg_data != r_acc);
                        end else begin
                            for (int i = 0; i < NENT; i++) begin
                                if (r_cnt == CW'(i))
                                    r_shadow[ENTRY_BITS*i +: ENTRY_BITS] <= cfg_data[ENTRY_BITS-1:0];
                            end
                            r_acc     <= r_acc ^ cfg_data;
                            r_illegal <= r_illegal | w_entry_illegal;
                            r_cnt     <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_switch_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_cfg_loader
// Brief    : Directed, table-driven self-checking bench for switch_cfg_loader.
// Revision : 1.0
// ============================================================================
module tb_switch_cfg_loader;

    localparam int NTB     = 5;
    localparam int NLR     = 4;
    localparam int TIMEOUT = 16;
    localparam int NENT    = 18;
    localparam int W       = 108;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [7:0]   cfg_data  = 8'h00;
    logic         clear     = 1'b0;
    logic         cfg_ready;
    logic [W-1:0] cfg_out;
    logic         busy;
    logic         cfg_done;
    logic         cfg_err;
    logic [1:0]   err_code;

    int checks = 0;
    int errors = 0;

    logic [7:0]   fr [NENT];
    logic [W-1:0] exp_out  = '0;
    logic [1:0]   exp_code = 2'd0;

    typedef struct {
        string      name;
        int         ka;
        logic [7:0] va;
        int         kb;
        logic [7:0] vb;
        logic [7:0] ck;
        bit         done;
        logic [1:0] code;
    } vec_t;

    vec_t vt [13];

    switch_cfg_loader #(
        .NTB     (NTB),
        .NLR     (NLR),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .clear     (clear),
        .cfg_out   (cfg_out),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_frame(input int ka, input logic [7:0] va, input int kb, input logic [7:0] vb);
        for (int k = 0; k < NENT; k++) fr[k] = 8'h00;
        if (ka >= 0) fr[ka] = va;
        if (kb >= 0) fr[kb] = vb;
    endtask

    // Called at a falling edge; returns at the falling edge after the byte transfers.
    task automatic send(input logic [7:0] b);
        int guard;
        guard     = 0;
        cfg_valid = 1'b1;
        cfg_data  = b;
        while (!cfg_ready && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (!cfg_ready) begin
            checks++;
            errors++;
            $display("FAIL send_ready: got 0 expected 1");
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic send_body(input logic [7:0] ck);
        for (int k = 0; k < NENT; k++) send(fr[k]);
        send(ck);
    endtask

    task automatic expect_result(input string name, input bit done, input logic [1:0] code);
        chk({name, "_chk_busy"}, busy, 1);
        chk({name, "_chk_ready"}, cfg_ready, 0);
        chk({name, "_early_done"}, cfg_done, 0);
        chk({name, "_early_err"}, cfg_err, 0);
        @(negedge clk);
        if (done) begin
            for (int k = 0; k < NENT; k++) exp_out[6*k +: 6] = fr[k][5:0];
        end
        exp_code = code;
        chk({name, "_done"}, cfg_done, done);
        chk({name, "_err"}, cfg_err, !done);
        chk({name, "_code"}, err_code, exp_code);
        chk({name, "_out"}, cfg_out, exp_out);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_ready"}, cfg_ready, 1);
        @(negedge clk);
        chk({name, "_done_pulse"}, cfg_done, 0);
        chk({name, "_err_pulse"}, cfg_err, 0);
        chk({name, "_code_hold"}, err_code, exp_code);
    endtask

    initial begin
        vt[0]  = '{"zero",     -1, 8'h00, -1, 8'h00, 8'h00, 1'b1, 2'd0};
        vt[1]  = '{"route",     0, 8'h0B, 17, 8'h0C, 8'h07, 1'b1, 2'd0};
        vt[2]  = '{"cksum",     0, 8'h0B, 17, 8'h0C, 8'h08, 1'b0, 2'd1};
        vt[3]  = '{"lr_range", 10, 8'h22, -1, 8'h00, 8'h22, 1'b0, 2'd2};
        vt[4]  = '{"self_top",  2, 8'h11, -1, 8'h00, 8'h11, 1'b0, 2'd2};
        vt[5]  = '{"prec",      2, 8'h11, -1, 8'h00, 8'h00, 1'b0, 2'd2};
        vt[6]  = '{"hibits",    5, 8'hC0, -1, 8'h00, 8'hC0, 1'b0, 2'd2};
        vt[7]  = '{"side5",     3, 8'h05, -1, 8'h00, 8'h05, 1'b0, 2'd2};
        vt[8]  = '{"tb_range",  0, 8'h29, -1, 8'h00, 8'h29, 1'b0, 2'd2};
        vt[9]  = '{"self_bot",  5, 8'h03, -1, 8'h00, 8'h03, 1'b0, 2'd2};
        vt[10] = '{"self_rt",  14, 8'h02, -1, 8'h00, 8'h02, 1'b0, 2'd2};
        vt[11] = '{"none_idx",  4, 8'h38, 14, 8'h21, 8'h19, 1'b1, 2'd0};
        vt[12] = '{"lr_ok",    10, 8'h1A,  5, 8'h0B, 8'h11, 1'b1, 2'd0};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_out", cfg_out, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", cfg_done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_code", err_code, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        for (int i = 0; i < 13; i++) begin
            set_frame(vt[i].ka, vt[i].va, vt[i].kb, vt[i].vb);
            send(8'hA5);
            send_body(vt[i].ck);
            expect_result(vt[i].name, vt[i].done, vt[i].code);
        end

        // Inter-byte timeout: error exactly TIMEOUT cycles after the last byte.
        set_frame(-1, 8'h00, -1, 8'h00);
        send(8'hA5);
        for (int k = 0; k < 5; k++) send(8'h00);
        for (int c = 1; c < TIMEOUT; c++) begin
            @(negedge clk);
            chk("to_wait_err", cfg_err, 0);
        end
        chk("to_wait_busy", busy, 1);
        @(negedge clk);
        exp_code = 2'd3;
        chk("to_err", cfg_err, 1);
        chk("to_code", err_code, exp_code);
        chk("to_busy", busy, 0);
        chk("to_out", cfg_out, exp_out);
        @(negedge clk);
        chk("to_pulse", cfg_err, 0);
        set_frame(1, 8'h13, -1, 8'h00);
        send(8'hA5);
        send_body(8'h13);
        expect_result("to_next", 1'b1, 2'd0);

        // Junk before the header, then valid held through CHECK.
        send(8'h00);
        chk("junk0_busy", busy, 0);
        send(8'h3C);
        chk("junk1_busy", busy, 0);
        set_frame(0, 8'h0B, 17, 8'h0C);
        send(8'hA5);
        send_body(8'h07);
        cfg_valid = 1'b1;
        cfg_data  = 8'hA5;
        chk("hold_ready_low", cfg_ready, 0);
        @(negedge clk);
        for (int k = 0; k < NENT; k++) exp_out[6*k +: 6] = fr[k][5:0];
        exp_code = 2'd0;
        chk("hold_done", cfg_done, 1);
        chk("hold_out", cfg_out, exp_out);
        chk("hold_ready_back", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("hold_hdr_taken", busy, 1);
        set_frame(-1, 8'h00, -1, 8'h00);
        send_body(8'h00);
        expect_result("hold_next", 1'b1, 2'd0);

        // Clear mid-frame after an error left err_code nonzero.
        set_frame(0, 8'h0B, 17, 8'h0C);
        send(8'hA5);
        send_body(8'h07);
        expect_result("pre_clr", 1'b1, 2'd0);
        send(8'hA5);
        send_body(8'h08);
        expect_result("pre_clr_err", 1'b0, 2'd1);
        send(8'hA5);
        send(8'h0B);
        send(8'h00);
        cfg_valid = 1'b1;
        cfg_data  = 8'hA5;
        clear     = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        cfg_valid = 1'b0;
        exp_out   = '0;
        exp_code  = 2'd0;
        chk("clr_busy", busy, 0);
        chk("clr_out", cfg_out, exp_out);
        chk("clr_code", err_code, exp_code);
        chk("clr_done", cfg_done, 0);
        chk("clr_err", cfg_err, 0);
        chk("clr_ready", cfg_ready, 1);
        @(negedge clk);
        chk("clr_done2", cfg_done, 0);
        chk("clr_err2", cfg_err, 0);

        // Reset mid-frame: remainder of the frame must not commit.
        set_frame(0, 8'h0B, 17, 8'h0C);
        send(8'hA5);
        send_body(8'h07);
        expect_result("pre_rst", 1'b1, 2'd0);
        send(8'hA5);
        for (int k = 0; k < 5; k++) send(fr[k]);
        rst_n = 1'b0;
        #1;
        chk("mrst_out", cfg_out, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", cfg_ready, 1);
        chk("mrst_code", err_code, 0);
        chk("mrst_done", cfg_done, 0);
        chk("mrst_err", cfg_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 5; k < NENT; k++) send(fr[k]);
        send(8'h07);
        chk("mrst_tail_busy", busy, 0);
        @(negedge clk);
        chk("mrst_tail_done", cfg_done, 0);
        chk("mrst_tail_out", cfg_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
